// File: rtl/apb_master_mux.sv
// APB4 master bridge: latches single-beat host commands and drives one of SLAVE_DEVICES slaves.
// Decodes the top address bits to pick a psel line; reports OKAY/SLVERR/DECERR/TIMEOUT.
module apb_master_mux #(
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned SLAVE_DEVICES  = 4,
    parameter int unsigned TIMEOUT_CYCLE  = 16
) (
    input  logic                        apb_clk_in,
    input  logic                        apb_rstn_in,
    output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
    output logic [SLAVE_DEVICES-1:0]    apb_psel_out,
    output logic                        apb_penable_out,
    output logic                        apb_write_out,
    output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
    output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
    output logic [2:0]                  apb_prot_out,
    input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
    input  logic                        apb_ready_in,
    input  logic                        apb_slverr_in,
    input  logic                        other_req_valid_in,
    output logic                        other_req_ready_out,
    input  logic [APB_ADDR_WIDTH-1:0]   other_addr_in,
    input  logic                        other_write_in,
    input  logic [APB_DATA_WIDTH-1:0]   other_wdata_in,
    input  logic [APB_DATA_WIDTH/8-1:0] other_strb_in,
    input  logic [2:0]                  other_prot_in,
    output logic                        other_rsp_valid_out,
    input  logic                        other_rsp_ready_in,
    output logic [APB_DATA_WIDTH-1:0]   other_rdata_out,
    output logic [1:0]                  other_rsp_err_out
);

    localparam int unsigned SEL_WIDTH  = (SLAVE_DEVICES <= 1) ? 1 : $clog2(SLAVE_DEVICES);
    localparam int unsigned STRB_WIDTH = APB_DATA_WIDTH / 8;
    localparam int unsigned CNT_WIDTH  = (TIMEOUT_CYCLE == 0) ? 1 : $clog2(TIMEOUT_CYCLE + 1);
    localparam logic [SLAVE_DEVICES-1:0] PSEL_ONE = SLAVE_DEVICES'(1);

    localparam logic [1:0] ERR_OKAY    = 2'b00;
    localparam logic [1:0] ERR_SLVERR  = 2'b01;
    localparam logic [1:0] ERR_DECERR  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [SLAVE_DEVICES-1:0]  psel_q, psel_d;
    logic                      penable_q, penable_d;
    logic                      write_q, write_d;
    logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0]     strb_q, strb_d;
    logic [2:0]                prot_q, prot_d;
    logic                      rsp_valid_q, rsp_valid_d;
    logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]                err_q, err_d;
    logic [CNT_WIDTH-1:0]      cnt_q, cnt_d;

    logic [SEL_WIDTH-1:0] idx;
    logic                 dec_hit;
    logic                 timeout_hit;

    assign idx         = other_addr_in[APB_ADDR_WIDTH-1 -: SEL_WIDTH];
    assign dec_hit     = 32'(idx) < SLAVE_DEVICES;
    // Fires on the TIMEOUT_CYCLE-th ACCESS cycle: the counter holds the number of waits so far.
    assign timeout_hit = (TIMEOUT_CYCLE != 0) && (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLE - 1));

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (other_req_valid_in) state_d = dec_hit ? StSetup : StResp;
            StSetup:  state_d = StAccess;
            StAccess: if (apb_ready_in || timeout_hit) state_d = StResp;
            StResp:   if (other_rsp_ready_in) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        addr_d      = addr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        prot_d      = prot_q;
        rsp_valid_d = rsp_valid_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (other_req_valid_in) begin
                    cnt_d = '0;
                    if (dec_hit) begin
                        addr_d    = other_addr_in;
                        psel_d    = PSEL_ONE << idx;
                        penable_d = 1'b0;
                        write_d   = other_write_in;
                        wdata_d   = other_write_in ? other_wdata_in : '0;
                        strb_d    = other_write_in ? other_strb_in : '0;
                        prot_d    = other_prot_in;
                    end else begin
                        rsp_valid_d = 1'b1;
                        rdata_d     = '0;
                        err_d       = ERR_DECERR;
                    end
                end
            end
            StSetup: penable_d = 1'b1;
            StAccess: begin
                if (apb_ready_in) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = write_q ? '0 : apb_rdata_in;
                    err_d       = apb_slverr_in ? ERR_SLVERR : ERR_OKAY;
                end else if (timeout_hit) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rdata_d     = '0;
                    err_d       = ERR_TIMEOUT;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            StResp: begin
                if (other_rsp_ready_in) begin
                    rsp_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
        if (!apb_rstn_in) begin
            addr_q      <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            prot_q      <= '0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            err_q       <= ERR_OKAY;
            cnt_q       <= '0;
        end else begin
            addr_q      <= addr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            prot_q      <= prot_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign other_req_ready_out = (state_q == StIdle);
    assign apb_addr_out        = addr_q;
    assign apb_psel_out        = psel_q;
    assign apb_penable_out     = penable_q;
    assign apb_write_out       = write_q;
    assign apb_wdata_out       = wdata_q;
    assign apb_strb_out        = strb_q;
    assign apb_prot_out        = prot_q;
    assign other_rsp_valid_out = rsp_valid_q;
    assign other_rdata_out     = rdata_q;
    assign other_rsp_err_out   = err_q;

endmodule

// File: tb/tb_apb_master_mux.sv
// Directed bench for apb_master_mux: a 4-slave/timeout-16 instance and a 3-slave instance
// (for the out-of-range decode), checked with immediate assertions.
module tb_apb_master_mux;

    logic        clk = 1'b0;
    logic        rstn;
    always #5 clk = ~clk;

    logic [31:0] addr;
    logic        write;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    logic        valid4, rsp_ready4;
    logic [31:0] paddr4, pwdata4, rdata4;
    logic [3:0]  psel4, pstrb4;
    logic        penable4, pwrite4, req_ready4, rsp_valid4;
    logic [2:0]  pprot4;
    logic [1:0]  err4;

    logic        valid3, rsp_ready3;
    logic [31:0] paddr3, pwdata3, rdata3;
    logic [2:0]  psel3;
    logic [3:0]  pstrb3;
    logic        penable3, pwrite3, req_ready3, rsp_valid3;
    logic [2:0]  pprot3;
    logic [1:0]  err3;

    apb_master_mux #(
        .APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .SLAVE_DEVICES(4), .TIMEOUT_CYCLE(16)
    ) u_dut4 (
        .apb_clk_in(clk), .apb_rstn_in(rstn),
        .apb_addr_out(paddr4), .apb_psel_out(psel4), .apb_penable_out(penable4),
        .apb_write_out(pwrite4), .apb_wdata_out(pwdata4), .apb_strb_out(pstrb4),
        .apb_prot_out(pprot4), .apb_rdata_in(prdata), .apb_ready_in(pready),
        .apb_slverr_in(pslverr), .other_req_valid_in(valid4), .other_req_ready_out(req_ready4),
        .other_addr_in(addr), .other_write_in(write), .other_wdata_in(wdata),
        .other_strb_in(strb), .other_prot_in(prot), .other_rsp_valid_out(rsp_valid4),
        .other_rsp_ready_in(rsp_ready4), .other_rdata_out(rdata4), .other_rsp_err_out(err4)
    );

    apb_master_mux #(
        .APB_DATA_WIDTH(32), .APB_ADDR_WIDTH(32), .SLAVE_DEVICES(3), .TIMEOUT_CYCLE(0)
    ) u_dut3 (
        .apb_clk_in(clk), .apb_rstn_in(rstn),
        .apb_addr_out(paddr3), .apb_psel_out(psel3), .apb_penable_out(penable3),
        .apb_write_out(pwrite3), .apb_wdata_out(pwdata3), .apb_strb_out(pstrb3),
        .apb_prot_out(pprot3), .apb_rdata_in(prdata), .apb_ready_in(pready),
        .apb_slverr_in(pslverr), .other_req_valid_in(valid3), .other_req_ready_out(req_ready3),
        .other_addr_in(addr), .other_write_in(write), .other_wdata_in(wdata),
        .other_strb_in(strb), .other_prot_in(prot), .other_rsp_valid_out(rsp_valid3),
        .other_rsp_ready_in(rsp_ready3), .other_rdata_out(rdata3), .other_rsp_err_out(err3)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pen_cnt;
        rstn = 1'b0;
        valid4 = 1'b0; rsp_ready4 = 1'b1;
        valid3 = 1'b0; rsp_ready3 = 1'b1;
        addr = '0; write = 1'b0; wdata = '0; strb = '0; prot = '0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;

        #3;
        chk("rst_psel", 64'(psel4), 64'h0);
        chk("rst_penable", 64'(penable4), 64'h0);
        chk("rst_rsp_valid", 64'(rsp_valid4), 64'h0);
        chk("rst_addr", 64'(paddr4), 64'h0);
        #19 rstn = 1'b1;
        tick();
        chk("idle_req_ready", 64'(req_ready4), 64'h1);

        // Zero-wait write to slave 1
        valid4 = 1'b1; addr = 32'h4000_0010; write = 1'b1; wdata = 32'h1234_5678;
        strb = 4'b0110; prot = 3'b010; pready = 1'b1; prdata = 32'h5555_AAAA;
        tick();
        chk("wr_setup_psel", 64'(psel4), 64'h2);
        chk("wr_setup_penable", 64'(penable4), 64'h0);
        chk("wr_setup_addr", 64'(paddr4), 64'h4000_0010);
        chk("wr_setup_pwrite", 64'(pwrite4), 64'h1);
        chk("wr_setup_wdata", 64'(pwdata4), 64'h1234_5678);
        chk("wr_setup_strb", 64'(pstrb4), 64'h6);
        chk("wr_setup_prot", 64'(pprot4), 64'h2);
        chk("wr_setup_req_ready", 64'(req_ready4), 64'h0);
        valid4 = 1'b0;
        tick();
        chk("wr_access_psel", 64'(psel4), 64'h2);
        chk("wr_access_penable", 64'(penable4), 64'h1);
        chk("wr_access_rsp_valid", 64'(rsp_valid4), 64'h0);
        tick();
        chk("wr_rsp_valid", 64'(rsp_valid4), 64'h1);
        chk("wr_rsp_err", 64'(err4), 64'h0);
        chk("wr_rsp_rdata", 64'(rdata4), 64'h0);
        chk("wr_rsp_psel", 64'(psel4), 64'h0);
        chk("wr_rsp_penable", 64'(penable4), 64'h0);
        tick();
        chk("wr_done_rsp_valid", 64'(rsp_valid4), 64'h0);
        chk("wr_done_req_ready", 64'(req_ready4), 64'h1);

        // Read from slave 3 with two wait cycles
        pready = 1'b0; valid4 = 1'b1; addr = 32'hC000_0004; write = 1'b0;
        wdata = 32'hFFFF_FFFF; strb = 4'hF; prot = 3'b000;
        tick();
        chk("rd_setup_psel", 64'(psel4), 64'h8);
        chk("rd_setup_wdata", 64'(pwdata4), 64'h0);
        chk("rd_setup_strb", 64'(pstrb4), 64'h0);
        chk("rd_setup_pwrite", 64'(pwrite4), 64'h0);
        valid4 = 1'b0;
        tick();
        chk("rd_access1_penable", 64'(penable4), 64'h1);
        tick();
        chk("rd_access2_penable", 64'(penable4), 64'h1);
        chk("rd_access2_psel", 64'(psel4), 64'h8);
        tick();
        chk("rd_access3_penable", 64'(penable4), 64'h1);
        chk("rd_access3_rsp_valid", 64'(rsp_valid4), 64'h0);
        pready = 1'b1; prdata = 32'hDEAD_BEEF;
        tick();
        chk("rd_rsp_valid", 64'(rsp_valid4), 64'h1);
        chk("rd_rsp_rdata", 64'(rdata4), 64'hDEAD_BEEF);
        chk("rd_rsp_err", 64'(err4), 64'h0);
        chk("rd_rsp_psel", 64'(psel4), 64'h0);
        chk("rd_rsp_penable", 64'(penable4), 64'h0);
        pready = 1'b0;
        tick();
        chk("rd_done_req_ready", 64'(req_ready4), 64'h1);

        // Out-of-range decode on the 3-slave instance
        valid3 = 1'b1; addr = 32'hC000_0000; write = 1'b0;
        tick();
        chk("dec_rsp_valid", 64'(rsp_valid3), 64'h1);
        chk("dec_err", 64'(err3), 64'h2);
        chk("dec_rdata", 64'(rdata3), 64'h0);
        chk("dec_psel", 64'(psel3), 64'h0);
        chk("dec_penable", 64'(penable3), 64'h0);
        valid3 = 1'b0;
        tick();
        chk("dec_done_req_ready", 64'(req_ready3), 64'h1);
        chk("dec_done_rsp_valid", 64'(rsp_valid3), 64'h0);

        // Timeout with pready stuck low
        valid4 = 1'b1; addr = 32'h0000_0100; write = 1'b0; pready = 1'b0;
        tick();
        chk("to_setup_psel", 64'(psel4), 64'h1);
        valid4 = 1'b0;
        pen_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rsp_valid4) break;
            if (penable4) pen_cnt++;
        end
        chk("to_rsp_valid", 64'(rsp_valid4), 64'h1);
        chk("to_penable_cycles", 64'(pen_cnt), 64'd16);
        chk("to_psel", 64'(psel4), 64'h0);
        chk("to_penable", 64'(penable4), 64'h0);
        chk("to_err", 64'(err4), 64'h3);
        chk("to_rdata", 64'(rdata4), 64'h0);
        tick();
        chk("to_done_req_ready", 64'(req_ready4), 64'h1);

        // Slave error with response back-pressure, then back-to-back accept
        rsp_ready4 = 1'b0; valid4 = 1'b1; addr = 32'h8000_0000; write = 1'b1;
        wdata = 32'h0BAD_F00D; strb = 4'hF; pready = 1'b1; pslverr = 1'b1;
        tick();
        chk("se_setup_psel", 64'(psel4), 64'h4);
        valid4 = 1'b0;
        tick();
        tick();
        chk("se_rsp_valid", 64'(rsp_valid4), 64'h1);
        chk("se_rsp_err", 64'(err4), 64'h1);
        valid4 = 1'b1; addr = 32'h4000_0020; write = 1'b0; pslverr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("se_hold_rsp_valid", 64'(rsp_valid4), 64'h1);
            chk("se_hold_err", 64'(err4), 64'h1);
            chk("se_hold_req_ready", 64'(req_ready4), 64'h0);
        end
        rsp_ready4 = 1'b1;
        tick();
        chk("se_hs_rsp_valid", 64'(rsp_valid4), 64'h0);
        chk("se_hs_req_ready", 64'(req_ready4), 64'h1);
        tick();
        chk("b2b_setup_psel", 64'(psel4), 64'h2);
        chk("b2b_setup_addr", 64'(paddr4), 64'h4000_0020);
        valid4 = 1'b0; pready = 1'b0;
        tick();
        chk("b2b_access_penable", 64'(penable4), 64'h1);

        // Asynchronous reset in the middle of ACCESS
        #2 rstn = 1'b0;
        #1;
        chk("arst_psel", 64'(psel4), 64'h0);
        chk("arst_penable", 64'(penable4), 64'h0);
        chk("arst_rsp_valid", 64'(rsp_valid4), 64'h0);
        #3 rstn = 1'b1;
        tick();
        chk("arst_post_req_ready", 64'(req_ready4), 64'h1);
        chk("arst_post_psel", 64'(psel4), 64'h0);
        chk("arst_post_rsp_valid", 64'(rsp_valid4), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/apb_master_mux.md
# apb_master_mux

Parametrised APB4 master bridge that accepts single-beat commands from an internal host over a valid/ready handshake and drives one of SLAVE_DEVICES APB slaves, selected by decoding the upper address bits. Commands are latched at acceptance, so the APB phase stays stable regardless of host activity. Responses carry read data and a 2-bit status: OKAY, SLVERR, DECERR or TIMEOUT. The block sits between on-chip host logic and the APB peripheral fabric.

## Interface
- APB_DATA_WIDTH, 32, data bus width (multiple of 8)
- APB_ADDR_WIDTH, 32, address bus width
- SLAVE_DEVICES, 4, number of psel lines (1..16)
- TIMEOUT_CYCLE, 16, max ACCESS cycles before abort; 0 disables timeout
- SEL_WIDTH, $clog2(SLAVE_DEVICES) (1 when SLAVE_DEVICES=1), local; decode field = paddr[APB_ADDR_WIDTH-1 -: SEL_WIDTH]
- apb_clk_in  in  1  clock; one clock, all logic on posedge
- apb_rstn_in  in  1  reset, asynchronous, active-low
- apb_addr_out  out  APB_ADDR_WIDTH  paddr
- apb_psel_out  out  SLAVE_DEVICES  one-hot psel
- apb_penable_out  out  1  penable
- apb_write_out  out  1  pwrite
- apb_wdata_out  out  APB_DATA_WIDTH  pwdata
- apb_strb_out  out  APB_DATA_WIDTH/8  pstrb
- apb_prot_out  out  3  pprot
- apb_rdata_in  in  APB_DATA_WIDTH  prdata (muxed by fabric)
- apb_ready_in  in  1  pready
- apb_slverr_in  in  1  pslverr
- other_req_valid_in / other_req_ready_out  in/out  1  command handshake
- other_addr_in, other_write_in, other_wdata_in, other_strb_in, other_prot_in  in  as APB  command fields
- other_rsp_valid_out / other_rsp_ready_in  out/in  1  response handshake
- other_rdata_out  out  APB_DATA_WIDTH  read data; 0 for writes and errors
- other_rsp_err_out  out  2  00 OKAY, 01 SLVERR, 10 DECERR, 11 TIMEOUT

## Operation
- States: IDLE, SETUP, ACCESS, RESP. Reset enters IDLE. All outputs are registered except other_req_ready_out, which is 1 only in IDLE.
- IDLE, valid=1: accept and latch all command fields. If the decode index is below SLAVE_DEVICES, go to SETUP. Otherwise go directly to RESP with err=10, rdata=0, and no APB activity.
- SETUP: drive psel[idx]=1, penable=0, and the latched addr/write/prot. On writes, drive wdata and strb from the command. On reads, drive wdata=0 and strb=0. The next state is always ACCESS.
- ACCESS: penable=1. All APB outputs hold stable.
  - If pready=1: go to RESP. psel and penable drop to 0. Capture rdata (reads only, else 0) and set err = pslverr ? 01 : 00.
  - If pready=0: increment the wait counter.
  - If TIMEOUT_CYCLE≠0 and pready is still 0 at the TIMEOUT_CYCLE-th ACCESS cycle: abort to RESP with err=11, rdata=0, psel and penable dropped.
- RESP: rsp_valid=1, with rdata and err held. When rsp_ready=1, go to IDLE, clear rsp_valid and clear the counter.
- The wait counter is $clog2(TIMEOUT_CYCLE+1) bits wide, is cleared on entering SETUP, and never wraps.
- pslverr is sampled only when pready=1 in ACCESS.

## Timing
- Reset (asynchronous assert, synchronous release): all outputs 0, state IDLE, rsp_valid=0, psel=0. Reset during any state drops psel and penable immediately and discards the command without a response.
- Zero-wait transfer: accept edge E → SETUP visible after E → ACCESS after E+1 → pready sampled high at E+2 → rsp_valid visible after E+2. Each wait cycle adds 1 cycle.
- DECERR: rsp_valid is visible after the accept edge E (latency 1).
- Back-to-back: a new request can be accepted at the first edge after the RESP handshake. Minimum 4 cycles per transfer.
- Timeout abort: a transfer spends exactly TIMEOUT_CYCLE cycles in ACCESS.

## Test plan
- Write addr 0x4000_0010, SLAVE_DEVICES=4, pready=1 in ACCESS → psel=0b0010 for one SETUP and one ACCESS cycle, pwdata/pstrb = command values, rsp err=00 with latency 3.
- Read addr 0xC000_0004, 2 wait cycles, prdata=0xDEADBEEF → psel=0b1000, penable high for 3 cycles, rdata=0xDEADBEEF, err=00, pstrb=0.
- SLAVE_DEVICES=3, addr 0xC000_0000 → no psel asserted, rsp_valid after 1 cycle, err=10, rdata=0.
- TIMEOUT_CYCLE=16, pready held 0 → penable high for exactly 16 cycles, then psel=0, err=11.
- Completion with pslverr=1, plus rsp_ready held low for 5 cycles → err=01 held stable, req_ready=0 throughout, and a new request is accepted on the edge after rsp_ready rises.
- Assert apb_rstn_in low mid-ACCESS → psel, penable and rsp_valid go 0 asynchronously. After release, state is IDLE and req_ready=1.
